// File: rtl/dac_tx.sv
// dac_tx: buffers application samples in a small FIFO and paces them out
// to a parallel SDR DAC at SYS_CLK/CLK_DIV, generating DAC_CLK locally.
module dac_tx #(
   parameter int DATA_WIDTH  = 10,
   parameter int CLK_DIV     = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int PRIME_LEVEL = 4,
   parameter logic [DATA_WIDTH-1:0] IDLE_CODE =
      {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
   input  logic                          SYS_CLK,
   input  logic                          RESET,
   input  logic                          ENABLE,
   input  logic [DATA_WIDTH-1:0]         APP_DATA,
   input  logic                          APP_DATA_VALID,
   output logic                          APP_DATA_READY,
   output logic                          DAC_CLK,
   output logic [DATA_WIDTH-1:0]         DAC_D,
   output logic                          STREAMING,
   output logic                          UNDERRUN,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  dac_clk_q, dac_clk_d;
   logic [DATA_WIDTH-1:0] dac_d_q, dac_d_d;
   logic                  underrun_q, underrun_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                  tick;
   logic                  ready;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic [DATA_WIDTH-1:0] rd_data;

   // Free-running divider; DAC_CLK rises halfway through each sample.
   always_comb begin
      tick      = (cnt_q == CW'(CLK_DIV - 1));
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      dac_clk_d = (cnt_d >= CW'(CLK_DIV / 2));
   end

   // A push coinciding with ENABLE low is dropped.
   always_comb begin
      ready   = (state_q != S_IDLE) && (level_q != LW'(FIFO_DEPTH));
      push    = APP_DATA_VALID && ready && ENABLE;
      rd_data = mem_q[rd_ptr_q];
   end

   always_comb begin
      state_d    = state_q;
      dac_d_d    = dac_d_q;
      underrun_d = underrun_q;
      pop        = 1'b0;
      flush      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            dac_d_d = IDLE_CODE;
            flush   = 1'b1;
            if (ENABLE) begin
               state_d    = S_PRIME;
               underrun_d = 1'b0;
            end
         end
         S_PRIME: begin
            if (!ENABLE) begin
               state_d = S_IDLE;
               flush   = 1'b1;
            end else if (tick && (level_q >= LW'(PRIME_LEVEL))) begin
               state_d = S_RUN;
               pop     = 1'b1;
               dac_d_d = rd_data;
            end
         end
         S_RUN: begin
            if (tick) begin
               if (!ENABLE) begin
                  state_d = S_IDLE;
                  flush   = 1'b1;
                  dac_d_d = IDLE_CODE;
               end else if (level_q != '0) begin
                  pop     = 1'b1;
                  dac_d_d = rd_data;
               end else begin
                  underrun_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            flush   = 1'b1;
            dac_d_d = IDLE_CODE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dac_clk_q  <= 1'b0;
         dac_d_q    <= IDLE_CODE;
         underrun_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dac_clk_q  <= dac_clk_d;
         dac_d_q    <= dac_d_d;
         underrun_q <= underrun_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   // Storage needs no reset: pointers and level gate every read.
   always_ff @(posedge SYS_CLK) begin
      if (push) mem_q[wr_ptr_q] <= APP_DATA;
   end

   assign APP_DATA_READY = ready;
   assign DAC_CLK        = dac_clk_q;
   assign DAC_D          = dac_d_q;
   assign STREAMING      = (state_q == S_RUN);
   assign UNDERRUN       = underrun_q;
   assign FIFO_LEVEL     = level_q;

endmodule

// File: doc/dac_tx.md
Name: dac_tx

Overview:
- Transmit-side counterpart to the ADC capture path for the acoustic carrier design.
- Accepts application samples over a valid/ready handshake and buffers them in a small FIFO.
- Paces samples out to an external parallel SDR DAC at SYS_CLK/CLK_DIV and generates the DAC sample clock from the same clock domain.
- Sits between the modulator/sample generator and the DAC pins.

Parameters:
DATA_WIDTH, 10, sample width in bits.
CLK_DIV, 4, SYS_CLK cycles per DAC sample. Even, >= 2.
FIFO_DEPTH, 8, sample buffer entries. Power of 2, >= 4.
PRIME_LEVEL, 4, FIFO level required before streaming starts. 1..FIFO_DEPTH.
IDLE_CODE, 10'h200, mid-scale code driven when not streaming.

Ports:
SYS_CLK  in  1  system clock; sole clock.
RESET  in  1  synchronous, active-high reset.
ENABLE  in  1  level; high = stream, low = return to idle.
APP_DATA  in  DATA_WIDTH  sample from application.
APP_DATA_VALID  in  1  APP_DATA valid.
APP_DATA_READY  out  1  block can accept a sample this cycle.
DAC_CLK  out  1  DAC sample clock (SYS_CLK/CLK_DIV, 50% duty, registered).
DAC_D  out  DATA_WIDTH  registered DAC data bus.
STREAMING  out  1  high while in RUN.
UNDERRUN  out  1  sticky, FIFO empty at a sample tick in RUN.
FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
Reset (synchronous, RESET=1 at a SYS_CLK edge):
- State = IDLE, divider cnt = 0, FIFO emptied.
- DAC_CLK=0, DAC_D=IDLE_CODE, APP_DATA_READY=0, STREAMING=0, UNDERRUN=0, FIFO_LEVEL=0.
- Reset mid-operation aborts immediately. No sample from before reset is ever output.

Divider:
- cnt counts 0..CLK_DIV-1 and wraps. It runs freely in all states after reset.
- DAC_CLK register = 1 when next cnt >= CLK_DIV/2, else 0. The rising DAC_CLK edge is mid-sample.
- Sample tick = cycle where cnt==CLK_DIV-1. DAC_D updates only on the edge ending a tick cycle, i.e. coincident with cnt becoming 0 and DAC_CLK low. This gives CLK_DIV/2 cycles of setup before the DAC_CLK rise.

FIFO:
- Synchronous, FIFO_DEPTH entries, first-word fall-through not required.
- Push when APP_DATA_VALID && APP_DATA_READY.
- APP_DATA_READY = (state != IDLE) && (level != FIFO_DEPTH).
- Pop occurs only at a sample tick in RUN with level > 0.
- Simultaneous push and pop: level unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- FIFO_LEVEL reflects the registered occupancy.

State machine:
- IDLE:
  - DAC_D held at IDLE_CODE; FIFO held empty.
  - ENABLE=1 -> PRIME and clear UNDERRUN.
- PRIME:
  - Accept data. DAC_D stays IDLE_CODE.
  - At a sample tick with level >= PRIME_LEVEL -> RUN, and the same tick pops the first sample onto DAC_D.
  - ENABLE=0 -> IDLE and flush the FIFO.
- RUN:
  - STREAMING=1.
  - Each sample tick: level > 0 -> pop to DAC_D. Level == 0 -> hold the previous DAC_D and set UNDERRUN. Stay in RUN; resume on the next tick with data.
  - ENABLE=0 -> at the next sample tick, DAC_D=IDLE_CODE, flush the FIFO, -> IDLE.
  - Samples pushed in the cycles before that tick are discarded.
- ENABLE=0 and a push in the same cycle: the push is dropped. APP_DATA_READY goes low on the IDLE entry cycle.

Test Plan:
1. Reset check: assert RESET 3 cycles with ENABLE=1 and VALID=1 -> DAC_D=0x200, DAC_CLK=0, READY=0, LEVEL=0, UNDERRUN=0; DAC_CLK toggles with period 4 after release.
2. Prime and stream (defaults):
   - Stimulus: ENABLE=1, push 0x001..0x006 back-to-back.
   - Required: READY high from the cycle after PRIME entry. DAC_D stays 0x200 until the first tick with LEVEL>=4. Then DAC_D = 0x001,0x002,... one per 4 cycles, each change aligned to cnt=0 with DAC_CLK low. STREAMING=1.
3. Backpressure: push 10 samples with no ticks consumed (still in PRIME) -> READY drops after 8 accepted, LEVEL=8. The 9th/10th are held by the source and accepted only after pops.
4. Underrun: stream 4 samples (0x100..0x103) then stop pushing -> DAC_D holds 0x103, UNDERRUN=1 and sticky, state stays RUN. A new push 0x104 appears at the following tick.
5. Disable mid-stream: drop ENABLE with LEVEL=3 -> at the next tick DAC_D=0x200, LEVEL=0, STREAMING=0, READY=0. Re-enabling clears UNDERRUN and re-primes.
6. Reset mid-RUN with LEVEL=5 -> next cycle all outputs at reset values. After release plus ENABLE, none of the old samples appear on DAC_D.
